// File: rtl/melody_sequencer_if.sv
// Control, note-table write and audio sample bundle between game logic and the melody sequencer.
// The master side drives control and table writes; the slave side (the sequencer) drives samples and status.
interface melody_sequencer_if #(
    parameter int AW       = 5,
    parameter int HALF_W   = 20,
    parameter int DUR_W    = 28,
    parameter int SAMPLE_W = 32
);
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [HALF_W-1:0]   wr_half;
    logic [DUR_W-1:0]    wr_dur;
    logic                wr_last;
    logic                start;
    logic                stop;
    logic                pause;
    logic                loop_en;
    logic                audio_out_allowed;
    logic                write_audio_out;
    logic [SAMPLE_W-1:0] left_out;
    logic [SAMPLE_W-1:0] right_out;
    logic                busy;
    logic [AW-1:0]       note_index;
    logic                done;

    modport master (
        output wr_en, wr_addr, wr_half, wr_dur, wr_last,
        output start, stop, pause, loop_en, audio_out_allowed,
        input  write_audio_out, left_out, right_out, busy, note_index, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_half, wr_dur, wr_last,
        input  start, stop, pause, loop_en, audio_out_allowed,
        output write_audio_out, left_out, right_out, busy, note_index, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// Square-wave melody player reading a writable note table (half-period, duration, last flag).
// One LOAD cycle per note, then dur PLAY cycles and GAP_CYCLES silent cycles; the sample strobe mirrors FIFO space.
module melody_sequencer #(
    parameter int DEPTH      = 32,
    parameter int HALF_W     = 20,
    parameter int DUR_W      = 28,
    parameter int SAMPLE_W   = 32,
    parameter int AMPLITUDE  = 100000000,
    parameter int GAP_CYCLES = 250000
) (
    input  logic CLOCK_50,
    input  logic reset,
    melody_sequencer_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam bit NO_GAP = (GAP_CYCLES == 0);
    localparam logic [AW-1:0]       LAST_IDX = AW'(DEPTH - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [SAMPLE_W-1:0] POS_AMP  = SAMPLE_W'(AMPLITUDE);
    localparam logic [SAMPLE_W-1:0] NEG_AMP  = SAMPLE_W'(-AMPLITUDE);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t state, state_nx;
    logic [AW-1:0]     idx, idx_nx;
    logic [HALF_W-1:0] half_r, fcount;
    logic [DUR_W-1:0]  dur_r, dcount;
    logic [GAP_W-1:0]  gcount;
    logic              last_r, sign, done_c;
    logic              play_end, note_fin, song_end;

    logic [HALF_W+DUR_W:0] note_mem [DEPTH];

    // Plain RAM: no reset, contents undefined until written.
    always_ff @(posedge CLOCK_50) begin
        if (bus.wr_en)
            note_mem[bus.wr_addr] <= {bus.wr_last, bus.wr_dur, bus.wr_half};
    end

    // A zero duration still plays for one cycle.
    assign play_end = (dur_r == '0) || (dcount == dur_r - 1'b1);
    assign note_fin = NO_GAP ? (state == PLAY && play_end) : (state == GAP && gcount == GAP_LAST);
    assign song_end = last_r || (idx == LAST_IDX);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        done_c   = 1'b0;
        if (bus.stop) begin
            state_nx = IDLE;
        end else if (bus.start) begin
            state_nx = LOAD;
            idx_nx   = '0;
        end else if (!bus.pause) begin
            case (state)
                LOAD:    state_nx = PLAY;
                PLAY:    if (play_end) state_nx = GAP;
                default: ;
            endcase
            if (note_fin) begin
                if (!song_end) begin
                    state_nx = LOAD;
                    idx_nx   = idx + 1'b1;
                end else if (bus.loop_en) begin
                    state_nx = LOAD;
                    idx_nx   = '0;
                end else begin
                    state_nx = IDLE;
                    done_c   = 1'b1;
                end
            end
        end
    end

    // Working registers only advance in unpaused, uncommanded cycles so pause resumes at the same phase.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            half_r <= '0;
            dur_r  <= '0;
            last_r <= 1'b0;
            fcount <= '0;
            dcount <= '0;
            sign   <= 1'b0;
            gcount <= '0;
        end else if (!bus.stop && !bus.start && !bus.pause) begin
            case (state)
                LOAD: begin
                    {last_r, dur_r, half_r} <= note_mem[idx];
                    fcount <= '0;
                    dcount <= '0;
                    sign   <= 1'b0;
                    gcount <= '0;
                end
                PLAY: begin
                    dcount <= dcount + 1'b1;
                    if (half_r != '0) begin
                        if (fcount == half_r - 1'b1) begin
                            fcount <= '0;
                            sign   <= ~sign;
                        end else begin
                            fcount <= fcount + 1'b1;
                        end
                    end
                end
                GAP:     gcount <= gcount + 1'b1;
                default: ;
            endcase
        end
    end

    logic [SAMPLE_W-1:0] sample;
    assign sample = (state == PLAY && half_r != '0 && !bus.pause) ? (sign ? NEG_AMP : POS_AMP) : '0;

    assign bus.left_out        = sample;
    assign bus.right_out       = sample;
    assign bus.write_audio_out = bus.audio_out_allowed;
    assign bus.busy            = (state != IDLE);
    assign bus.note_index      = idx;
    assign bus.done            = done_c;
endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: per-cycle expected samples/status are queued from a note-table model and popped each cycle.
module tb_melody_sequencer;
    localparam int DEPTH = 4, AW = 2, HALF_W = 8, DUR_W = 8, SAMPLE_W = 16;
    localparam int AMP = 1000, GAP = 2;
    localparam logic [15:0] POS = 16'(AMP);
    localparam logic [15:0] NEG = 16'(-AMP);

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #5 CLOCK_50 = ~CLOCK_50;

    melody_sequencer_if #(.AW(AW), .HALF_W(HALF_W), .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W)) bus ();

    melody_sequencer #(
        .DEPTH(DEPTH), .HALF_W(HALF_W), .DUR_W(DUR_W), .SAMPLE_W(SAMPLE_W),
        .AMPLITUDE(AMP), .GAP_CYCLES(GAP)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] smp;
        logic        busy;
        logic        done;
        logic [1:0]  idx;
        bit          idx_vld;
    } exp_t;

    exp_t sbq[$];
    int n_err = 0;
    int n_chk = 0;
    int busy_cnt = 0;
    logic [7:0] m_half [DEPTH];
    logic [7:0] m_dur  [DEPTH];
    bit         m_last [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] s, input logic b, input logic d, input int i, input bit v);
        exp_t e;
        e.smp = s; e.busy = b; e.done = d; e.idx = 2'(i); e.idx_vld = v;
        sbq.push_back(e);
    endtask

    // One note: LOAD, max(dur,1) tone/rest cycles, GAP silent cycles (done on the last if the song ends).
    task automatic push_note(input int n, input bit lp, output bit fin);
        int d, h;
        logic [15:0] s;
        d = (m_dur[n] == 0) ? 1 : int'(m_dur[n]);
        h = int'(m_half[n]);
        push(16'd0, 1'b1, 1'b0, n, 1'b1);
        for (int c = 0; c < d; c++) begin
            s = (h == 0) ? 16'd0 : ((((c / h) % 2) == 1) ? NEG : POS);
            push(s, 1'b1, 1'b0, n, 1'b1);
        end
        fin = m_last[n] || (n == DEPTH - 1);
        for (int g = 0; g < GAP; g++)
            push(16'd0, 1'b1, fin && !lp && (g == GAP - 1), n, 1'b1);
    endtask

    task automatic push_song(input bit lp);
        bit fin;
        for (int n = 0; n < DEPTH; n++) begin
            push_note(n, lp, fin);
            if (fin) break;
        end
        if (!lp) push(16'd0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                bus.audio_out_allowed = 1'($urandom_range(0, 1));
                @(negedge CLOCK_50);
                check("left", 32'(bus.left_out), 32'(e.smp));
                check("right", 32'(bus.right_out), 32'(e.smp));
                check("busy", 32'(bus.busy), 32'(e.busy));
                check("done", 32'(bus.done), 32'(e.done));
                if (e.idx_vld) check("note_index", 32'(bus.note_index), 32'(e.idx));
                check("wr_strobe", 32'(bus.write_audio_out), 32'(bus.audio_out_allowed));
                if (bus.busy) busy_cnt++;
                @(posedge CLOCK_50);
                #1;
            end
        end
    endtask

    task automatic run_all();
        run(sbq.size());
    endtask

    task automatic wr_entry(input int a, input int h, input int d, input bit l);
        bus.wr_en = 1'b1; bus.wr_addr = 2'(a); bus.wr_half = 8'(h); bus.wr_dur = 8'(d); bus.wr_last = l;
        @(posedge CLOCK_50);
        #1;
        bus.wr_en = 1'b0;
        m_half[a] = 8'(h); m_dur[a] = 8'(d); m_last[a] = l;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_half = 0; bus.wr_dur = 0; bus.wr_last = 0;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop_en = 0; bus.audio_out_allowed = 1;

        // Values held during reset
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_left", 32'(bus.left_out), 32'd0);
        check("rst_index", 32'(bus.note_index), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_strobe1", 32'(bus.write_audio_out), 32'd1);
        bus.audio_out_allowed = 0;
        #1;
        check("rst_strobe0", 32'(bus.write_audio_out), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;

        // Basic two-note song
        wr_entry(0, 3, 12, 1'b0);
        wr_entry(1, 0, 4, 1'b1);
        wr_entry(2, 5, 5, 1'b0);
        wr_entry(3, 5, 5, 1'b0);
        pulse_start();
        push_song(1'b0);
        busy_cnt = 0;
        run_all();
        check("busy_len", 32'(busy_cnt), 32'd22);

        // Loop then stop in the 5th PLAY cycle of the second pass
        bus.loop_en = 1'b1;
        pulse_start();
        push_song(1'b1);
        push(16'd0, 1'b1, 1'b0, 0, 1'b1);
        for (int c = 0; c < 4; c++) push((c < 3) ? POS : NEG, 1'b1, 1'b0, 0, 1'b1);
        run_all();
        bus.stop = 1'b1;
        push(NEG, 1'b1, 1'b0, 0, 1'b1);
        run(1);
        bus.stop = 1'b0;
        bus.loop_en = 1'b0;
        push(16'd0, 1'b0, 1'b0, 0, 1'b0);
        push(16'd0, 1'b0, 1'b0, 0, 1'b0);
        run_all();

        // Pause for 5 cycles from the third PLAY cycle of entry 0
        pulse_start();
        push_song(1'b0);
        for (int k = 0; k < 5; k++) begin
            exp_t p;
            p.smp = 16'd0; p.busy = 1'b1; p.done = 1'b0; p.idx = 2'd0; p.idx_vld = 1'b1;
            sbq.insert(3, p);
        end
        busy_cnt = 0;
        run(3);
        bus.pause = 1'b1;
        run(5);
        bus.pause = 1'b0;
        run_all();
        check("pause_busy_len", 32'(busy_cnt), 32'd27);

        // start and stop together while idle
        bus.start = 1'b1; bus.stop = 1'b1;
        @(posedge CLOCK_50);
        #1;
        bus.start = 1'b0; bus.stop = 1'b0;
        push(16'd0, 1'b0, 1'b0, 0, 1'b0);
        push(16'd0, 1'b0, 1'b0, 0, 1'b0);
        run_all();

        // Restart during PLAY of entry 1
        pulse_start();
        push_song(1'b0);
        run(17);
        sbq.delete();
        bus.start = 1'b1;
        push(16'd0, 1'b1, 1'b0, 1, 1'b1);
        push_song(1'b0);
        run(1);
        bus.start = 1'b0;
        run_all();

        // Table write during playback only affects the next loop pass
        bus.loop_en = 1'b1;
        pulse_start();
        push_song(1'b1);
        run(4);
        bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_half = 8'd2; bus.wr_dur = 8'd12; bus.wr_last = 1'b0;
        run(1);
        bus.wr_en = 1'b0;
        m_half[0] = 8'd2;
        begin
            bit fin;
            push_note(0, 1'b1, fin);
        end
        void'(sbq.pop_back());
        void'(sbq.pop_back());
        run(sbq.size() - 1);
        bus.stop = 1'b1;
        run(1);
        bus.stop = 1'b0;
        bus.loop_en = 1'b0;
        push(16'd0, 1'b0, 1'b0, 0, 1'b0);
        run_all();

        // Wrap at the last entry with zero durations
        for (int n = 0; n < DEPTH; n++) wr_entry(n, 2, 0, 1'b0);
        pulse_start();
        push_song(1'b0);
        run_all();

        // Asynchronous reset in the middle of PLAY
        wr_entry(0, 3, 12, 1'b0);
        pulse_start();
        push_song(1'b0);
        run(3);
        sbq.delete();
        #2;
        reset = 1'b1;
        #1;
        check("arst_left", 32'(bus.left_out), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_index", 32'(bus.note_index), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;
        for (int k = 0; k < 3; k++) push(16'd0, 1'b0, 1'b0, 0, 1'b1);
        run_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Parametrised square-wave melody player that drives the audio controller's left/right sample inputs and write strobe. It replaces a hard-coded note list with a writable note table. Each entry holds a half-period, a duration and an end-of-song flag. The block adds start/stop/pause control, optional looping, rests, and a silent articulation gap between notes. It sits between game control logic and the audio controller.

## Interface
- DEPTH, 32: note table entries (power of two, ≥2); AW = $clog2(DEPTH)
- HALF_W, 20: half-period field width (cycles of CLOCK_50)
- DUR_W, 28: duration field width (cycles)
- SAMPLE_W, 32: output sample width, two's complement
- AMPLITUDE, 100000000: square-wave magnitude; must fit SAMPLE_W-1 bits
- GAP_CYCLES, 250000: silent cycles after every note; 0 allowed
- CLOCK_50  in  1  sole clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- wr_en  in  1  write note table this cycle
- wr_addr  in  AW  table address
- wr_half  in  HALF_W  half-period; 0 = rest (silence)
- wr_dur  in  DUR_W  note length in cycles; 0 treated as 1
- wr_last  in  1  entry ends the song
- start  in  1  pulse: begin at entry 0 (restarts if busy)
- stop  in  1  pulse: abort to IDLE
- pause  in  1  level: freeze sequencing, force silence
- loop_en  in  1  after last entry, continue at entry 0
- audio_out_allowed  in  1  controller output FIFO has space
- write_audio_out  out  1  sample write strobe
- left_out, right_out  out  SAMPLE_W  identical samples
- busy  out  1  state ≠ IDLE
- note_index  out  AW  entry being played
- done  out  1  one-cycle pulse at song end (non-loop)

## Operation
- States: IDLE, LOAD, PLAY, GAP.
- The table is synchronous-write RAM. Fields are latched into working registers in LOAD. Writes during playback are permitted; they affect only entries loaded afterwards.
- IDLE → LOAD on start. note_index ← 0.
- LOAD (1 cycle):
  - latch half/dur/last from entry note_index
  - fcount ← 0, dcount ← 0, sign ← 0
  - → PLAY
- PLAY lasts exactly max(dur,1) cycles (dcount 0..dur-1), then → GAP. If GAP_CYCLES=0, go straight to the end-of-note decision.
- Tone in PLAY with half≠0:
  - fcount counts 0..half-1
  - at half-1: fcount ← 0, sign toggles
- GAP lasts GAP_CYCLES cycles, then the end-of-note decision:
  - If last=1, or note_index=DEPTH-1 (wrap rule), and loop_en=1: note_index ← 0, → LOAD.
  - If last=1 or wrap, and loop_en=0: → IDLE, done=1 for the transition cycle.
  - Otherwise: note_index+1, → LOAD.
- Samples are combinational from registered state:
  - left_out = right_out = sign ? -AMPLITUDE : +AMPLITUDE in PLAY with half≠0 and pause=0
  - 0 in all other cases
- write_audio_out = audio_out_allowed in every state, so silence keeps the FIFO fed.
- pause=1 holds state, fcount, dcount, sign and note_index. On release, the waveform resumes at the same phase.
- Priority: reset > stop > start > pause > normal sequencing.
  - stop and start in the same cycle: stop wins, → IDLE.
  - start while busy: → LOAD at entry 0.
  - stop and start are honoured while paused.
- done does not assert on stop, on start-restart, or while looping.

## Timing
- Reset values:
  - state IDLE
  - left_out, right_out 0
  - write_audio_out = audio_out_allowed
  - busy 0, note_index 0, done 0
  - sign, fcount, dcount 0
- Reset assertion forces these values immediately, without waiting for a clock edge. Table contents are undefined after reset.
- start sampled at edge t: LOAD during cycle t+1, first PLAY sample (+AMPLITUDE) in cycle t+2.
- Per unpaused note, busy time is 1 (LOAD) + dur + GAP_CYCLES cycles.
- Square wave: half cycles +A, half cycles −A, repeating. A note ending mid half-period is truncated.
- stop at edge t: IDLE and zero output in cycle t+1.
- Counter widths are fixed by parameters; no saturation logic. A write and a LOAD read of the same address in the same cycle returns the old data.

## Test plan
- Reset: assert reset asynchronously mid-PLAY → outputs 0, busy 0, note_index 0 before the next edge. Deassert → stays IDLE, and write_audio_out follows audio_out_allowed.
- Basic song (DEPTH=4, GAP_CYCLES=2). Table {half=3,dur=12,last=0}, {half=0,dur=4,last=1}. Pulse start → required response:
  - 1 LOAD cycle
  - +A×3, −A×3, +A×3, −A×3
  - 2 zeros, LOAD, 4 zeros (rest), 2 zeros
  - done pulse, busy high exactly 22 cycles
- Loop/stop: same table with loop_en=1 → note_index goes 1→0 with no done pulse. stop in the 5th PLAY cycle → IDLE and output 0 next cycle, done stays 0.
- Pause: pause=1 for 5 cycles starting at PLAY cycle 2 of entry 0 → output 0 while paused. On release the remaining +A cycle appears first. Note busy time grows by 5.
- Control collisions:
  - start+stop together in IDLE → remains IDLE
  - start in PLAY of entry 1 → LOAD of entry 0 next cycle
  - wr_en to entry 0 during PLAY → current note unchanged, new value used on the next loop
- Wrap and dur=0: all 4 entries last=0, dur=0, loop_en=0 → each entry PLAYs 1 cycle. After entry 3's GAP → IDLE with a done pulse.
